// File: rtl/rpll_reconfig_ctrl.sv
// rtl/rpll_reconfig_ctrl.sv - Gowin rPLL dynamic-divider sequencer with lock supervision
module rpll_reconfig_ctrl #(
    parameter int NUM_PROFILES = 4,
    parameter int PROF_W = 2,
    parameter logic [6*NUM_PROFILES-1:0] IDSEL_TABLE  = '0,
    parameter logic [6*NUM_PROFILES-1:0] FBDSEL_TABLE = '0,
    parameter logic [6*NUM_PROFILES-1:0] ODSEL_TABLE  = '0,
    parameter int DEFAULT_PROFILE = 0,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES = 3
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [PROF_W-1:0] req_profile,
    output logic              req_ready,
    output logic              req_nack,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        pll_idsel,
    output logic [5:0]        pll_fbdsel,
    output logic [5:0]        pll_odsel,
    output logic [PROF_W-1:0] cur_profile,
    output logic              clk_stable,
    output logic              sys_rst_n,
    output logic              busy,
    output logic              error,
    output logic [7:0]        lock_lost_cnt
);
    localparam int CNT_MAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > PLL_RST_CYCLES) ? CNT_MAX0 : PLL_RST_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RTY_W    = $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 1 : 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILISE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RTY_W-1:0] retry, retry_nxt;
    logic             lock_meta, lock_sync;
    logic             accept, idx_ok, load_prof, nack_nxt, lost;

    logic [5:0] id_rom [NUM_PROFILES];
    logic [5:0] fb_rom [NUM_PROFILES];
    logic [5:0] od_rom [NUM_PROFILES];

    for (genvar k = 0; k < NUM_PROFILES; k++) begin : g_rom
        assign id_rom[k] = IDSEL_TABLE[6*k +: 6];
        assign fb_rom[k] = FBDSEL_TABLE[6*k +: 6];
        assign od_rom[k] = ODSEL_TABLE[6*k +: 6];
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET_PLL;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        load_prof = 1'b0;
        nack_nxt  = 1'b0;
        lost      = 1'b0;
        accept    = req_valid && req_ready;
        idx_ok    = int'(req_profile) < NUM_PROFILES;
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                // The cycle that first sees lock counts as the first stable cycle.
                if (lock_sync) begin
                    cnt_nxt = CNT_W'(1);
                    if (STABLE_CYCLES <= 1) begin
                        state_nxt = S_RUN;
                        retry_nxt = '0;
                    end else begin
                        state_nxt = S_STABILISE;
                    end
                end else if (cnt == TO_LAST) begin
                    cnt_nxt   = '0;
                    retry_nxt = retry + RTY_W'(1);
                    state_nxt = (retry == RTY_LAST) ? S_ERROR : S_RESET_PLL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STABILISE: begin
                if (!lock_sync) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STB_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_sync) begin
                    lost      = 1'b1;
                    state_nxt = S_RESET_PLL;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            default: ;
        endcase
        // A valid request overrides any lock-loss restart in the same cycle.
        if (accept) begin
            if (idx_ok) begin
                state_nxt = S_RESET_PLL;
                cnt_nxt   = '0;
                retry_nxt = '0;
                load_prof = 1'b1;
            end else begin
                nack_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset     <= 1'b1;
            sys_rst_n     <= 1'b0;
            clk_stable    <= 1'b0;
            busy          <= 1'b1;
            error         <= 1'b0;
            req_ready     <= 1'b0;
            req_nack      <= 1'b0;
            lock_lost_cnt <= '0;
            cur_profile   <= PROF_W'(DEFAULT_PROFILE);
            pll_idsel     <= IDSEL_TABLE[6*DEFAULT_PROFILE +: 6];
            pll_fbdsel    <= FBDSEL_TABLE[6*DEFAULT_PROFILE +: 6];
            pll_odsel     <= ODSEL_TABLE[6*DEFAULT_PROFILE +: 6];
        end else begin
            pll_reset  <= (state_nxt == S_RESET_PLL);
            sys_rst_n  <= (state_nxt == S_RUN);
            clk_stable <= (state_nxt == S_RUN);
            busy       <= (state_nxt == S_RESET_PLL) || (state_nxt == S_WAIT_LOCK) ||
                          (state_nxt == S_STABILISE);
            error      <= (state_nxt == S_ERROR);
            req_ready  <= (state_nxt == S_RUN) || (state_nxt == S_ERROR);
            req_nack   <= nack_nxt;
            if (lost && (lock_lost_cnt != 8'hFF)) begin
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
            end
            if (load_prof) begin
                cur_profile <= req_profile;
                pll_idsel   <= id_rom[req_profile];
                pll_fbdsel  <= fb_rom[req_profile];
                pll_odsel   <= od_rom[req_profile];
            end
        end
    end
endmodule

// File: tb/tb_rpll_reconfig_ctrl.sv
// tb/tb_rpll_reconfig_ctrl.sv - randomized self-checking bench for rpll_reconfig_ctrl
module tb_rpll_reconfig_ctrl;
    localparam int NP = 3;
    localparam int PW = 2;
    localparam int RST_CYC = 4;
    localparam int TIMEOUT = 20;
    localparam int STABLE = 8;
    localparam int RETRIES = 2;
    localparam logic [6*NP-1:0] ID_T = {6'h33, 6'h22, 6'h11};
    localparam logic [6*NP-1:0] FB_T = {6'h0C, 6'h1F, 6'h05};
    localparam logic [6*NP-1:0] OD_T = {6'h38, 6'h30, 6'h3C};
    // Lock needs two synchroniser cycles, then STABLE consecutive locked cycles.
    localparam int RUN_LAT = 2 + STABLE;

    logic          clkin = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [PW-1:0] req_profile = '0;
    logic          req_ready, req_nack;
    logic          pll_lock = 1'b0;
    logic          pll_reset;
    logic [5:0]    pll_idsel, pll_fbdsel, pll_odsel;
    logic [PW-1:0] cur_profile;
    logic          clk_stable, sys_rst_n, busy, error;
    logic [7:0]    lock_lost_cnt;

    int            checks = 0;
    int            fails = 0;
    int            model_lost = 0;
    logic [PW-1:0] model_prof = '0;

    rpll_reconfig_ctrl #(
        .NUM_PROFILES(NP), .PROF_W(PW),
        .IDSEL_TABLE(ID_T), .FBDSEL_TABLE(FB_T), .ODSEL_TABLE(OD_T),
        .DEFAULT_PROFILE(0), .PLL_RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(TIMEOUT),
        .STABLE_CYCLES(STABLE), .MAX_RETRIES(RETRIES)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .req_valid(req_valid), .req_profile(req_profile),
        .req_ready(req_ready), .req_nack(req_nack), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
        .pll_odsel(pll_odsel), .cur_profile(cur_profile), .clk_stable(clk_stable),
        .sys_rst_n(sys_rst_n), .busy(busy), .error(error), .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clkin = ~clkin;

    function automatic logic [17:0] exp_sel(input int k);
        logic [6*NP-1:0] id, fb, od;
        id = ID_T >> (6 * k);
        fb = FB_T >> (6 * k);
        od = OD_T >> (6 * k);
        return {id[5:0], fb[5:0], od[5:0]};
    endfunction

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    task automatic bring_up(input int d, output int n);
        int g;
        g = 0;
        while (pll_reset !== 1'b0 && g < 200) begin
            @(negedge clkin);
            g++;
        end
        repeat (d) @(negedge clkin);
        pll_lock = 1'b1;
        n = 0;
        while (sys_rst_n !== 1'b1 && n <= 200) begin
            @(negedge clkin);
            n++;
        end
        if (n > 200) n = -1;
    endtask

    task automatic request(input logic [PW-1:0] p);
        req_valid = 1'b1;
        req_profile = p;
        @(negedge clkin);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clkin);
        checks++;
        if (pll_reset !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_pll_busy: pll_reset=%b busy=%b, required 1 1", pll_reset, busy);
        end
        checks++;
        if ({sys_rst_n, clk_stable, error, req_ready, req_nack} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: srst/stable/err/rdy/nack=%b, required 00000",
                     {sys_rst_n, clk_stable, error, req_ready, req_nack});
        end
        checks++;
        if (lock_lost_cnt !== 8'd0 || cur_profile !== 2'd0) begin
            fails++;
            $display("FAIL reset_cnt_prof: lost=%0d prof=%0d, required 0 0", lock_lost_cnt, cur_profile);
        end
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(0)) begin
            fails++;
            $display("FAIL reset_selects: got %h, required %h", {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(0));
        end
    endtask

    task automatic test_power_up();
        int hi, g, n;
        logic prev_busy;
        rst_n = 1'b1;
        hi = 0;
        g = 0;
        while (pll_reset === 1'b1 && g < 50) begin
            hi++;
            g++;
            @(negedge clkin);
        end
        checks++;
        if (hi !== RST_CYC) begin
            fails++;
            $display("FAIL powerup_reset_len: %0d cycles, required %0d", hi, RST_CYC);
        end
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(0)) begin
            fails++;
            $display("FAIL powerup_selects: got %h, required %h", {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(0));
        end
        repeat (10) @(negedge clkin);
        pll_lock = 1'b1;
        n = 0;
        prev_busy = busy;
        while (sys_rst_n !== 1'b1 && n <= 100) begin
            prev_busy = busy;
            @(negedge clkin);
            n++;
        end
        checks++;
        if (n !== RUN_LAT) begin
            fails++;
            $display("FAIL powerup_run_latency: %0d cycles, required %0d", n, RUN_LAT);
        end
        checks++;
        if (busy !== 1'b0 || prev_busy !== 1'b1 || clk_stable !== 1'b1 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL powerup_run_flags: busy=%b prev_busy=%b stable=%b ready=%b, required 0 1 1 1",
                     busy, prev_busy, clk_stable, req_ready);
        end
    endtask

    task automatic test_reconfigure();
        int n;
        logic [PW-1:0] p, other;
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? 2'd2 : PW'($urandom_range(0, NP - 1));
            request(p);
            pll_lock = 1'b0;
            model_prof = p;
            checks++;
            if ({sys_rst_n, pll_reset, cur_profile} !== {1'b0, 1'b1, p} ||
                {pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(int'(p))) begin
                fails++;
                $display("FAIL reconfig_apply: srst=%b prst=%b prof=%0d sel=%h, required 0 1 %0d %h",
                         sys_rst_n, pll_reset, cur_profile, {pll_idsel, pll_fbdsel, pll_odsel}, p, exp_sel(int'(p)));
            end
            other = PW'((int'(p) + 1) % NP);
            request(other);
            checks++;
            if (cur_profile !== p || req_ready !== 1'b0 || pll_reset !== 1'b1) begin
                fails++;
                $display("FAIL busy_request_ignored: prof=%0d ready=%b prst=%b, required %0d 0 1",
                         cur_profile, req_ready, pll_reset, p);
            end
            bring_up($urandom_range(1, 15), n);
            checks++;
            if (n !== RUN_LAT) begin
                fails++;
                $display("FAIL reconfig_run_latency: %0d cycles, required %0d", n, RUN_LAT);
            end
        end
    endtask

    task automatic test_nack();
        request(2'd3);
        checks++;
        if (req_nack !== 1'b1 || cur_profile !== model_prof || sys_rst_n !== 1'b1 || pll_reset !== 1'b0) begin
            fails++;
            $display("FAIL nack_pulse: nack=%b prof=%0d srst=%b prst=%b, required 1 %0d 1 0",
                     req_nack, cur_profile, sys_rst_n, pll_reset, model_prof);
        end
        @(negedge clkin);
        checks++;
        if (req_nack !== 1'b0 || sys_rst_n !== 1'b1 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL nack_single: nack=%b srst=%b ready=%b, required 0 1 1", req_nack, sys_rst_n, req_ready);
        end
    endtask

    task automatic test_glitch();
        int n, k, g;
        logic early, prst_seen;
        logic [PW-1:0] p;
        for (int i = 0; i < 2; i++) begin
            p = PW'($urandom_range(0, NP - 1));
            request(p);
            pll_lock = 1'b0;
            model_prof = p;
            g = 0;
            while (pll_reset !== 1'b0 && g < 50) begin
                @(negedge clkin);
                g++;
            end
            repeat ($urandom_range(1, 10)) @(negedge clkin);
            pll_lock = 1'b1;
            k = $urandom_range(1, 7);
            early = 1'b0;
            prst_seen = 1'b0;
            repeat (k) begin
                @(negedge clkin);
                if (sys_rst_n !== 1'b0) early = 1'b1;
            end
            pll_lock = 1'b0;
            @(negedge clkin);
            if (sys_rst_n !== 1'b0) early = 1'b1;
            pll_lock = 1'b1;
            n = 0;
            while (sys_rst_n !== 1'b1 && n <= 100) begin
                @(negedge clkin);
                n++;
                if (pll_reset !== 1'b0) prst_seen = 1'b1;
            end
            checks++;
            if (n !== RUN_LAT || early || prst_seen) begin
                fails++;
                $display("FAIL glitch_restart: k=%0d latency=%0d early=%b pll_reset_seen=%b, required %0d 0 0",
                         k, n, early, prst_seen, RUN_LAT);
            end
        end
    endtask

    task automatic test_timeout_retry();
        int n, hi;
        logic [PW-1:0] p;
        p = PW'($urandom_range(0, NP - 1));
        request(p);
        pll_lock = 1'b0;
        n = 0;
        hi = 0;
        while (error !== 1'b1 && n < 200) begin
            if (pll_reset === 1'b1) hi++;
            @(negedge clkin);
            n++;
        end
        checks++;
        if (n !== RETRIES * (RST_CYC + TIMEOUT) || hi !== RETRIES * RST_CYC) begin
            fails++;
            $display("FAIL timeout_attempts: %0d cycles (%0d in reset), required %0d (%0d)",
                     n, hi, RETRIES * (RST_CYC + TIMEOUT), RETRIES * RST_CYC);
        end
        repeat (5) @(negedge clkin);
        checks++;
        if ({error, sys_rst_n, req_ready, pll_reset, busy} !== 5'b10100) begin
            fails++;
            $display("FAIL error_state: err/srst/rdy/prst/busy=%b, required 10100",
                     {error, sys_rst_n, req_ready, pll_reset, busy});
        end
        request(2'd1);
        model_prof = 2'd1;
        checks++;
        if (error !== 1'b0 || pll_reset !== 1'b1 || cur_profile !== 2'd1 ||
            {pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(1)) begin
            fails++;
            $display("FAIL error_recover: err=%b prst=%b prof=%0d sel=%h, required 0 1 1 %h",
                     error, pll_reset, cur_profile, {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(1));
        end
        bring_up($urandom_range(1, 15), n);
        checks++;
        if (n !== RUN_LAT) begin
            fails++;
            $display("FAIL recover_run_latency: %0d cycles, required %0d", n, RUN_LAT);
        end
    endtask

    task automatic test_lock_loss();
        int n, first_zero;
        logic [PW-1:0] q;
        pll_lock = 1'b0;
        first_zero = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clkin);
            if (sys_rst_n === 1'b0 && first_zero == 0) first_zero = i;
        end
        model_lost++;
        checks++;
        if (first_zero !== 3 || lock_lost_cnt !== sat8(model_lost)) begin
            fails++;
            $display("FAIL lock_loss: srst low after %0d cycles, count=%0d, required 3 %0d",
                     first_zero, lock_lost_cnt, sat8(model_lost));
        end
        bring_up($urandom_range(0, 5), n);
        q = PW'((int'(model_prof) + 1) % NP);
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin);
        request(q);
        model_lost++;
        model_prof = q;
        checks++;
        if (cur_profile !== q || pll_reset !== 1'b1 || lock_lost_cnt !== sat8(model_lost) ||
            {pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(int'(q))) begin
            fails++;
            $display("FAIL loss_and_request: prof=%0d prst=%b count=%0d, required %0d 1 %0d",
                     cur_profile, pll_reset, lock_lost_cnt, q, sat8(model_lost));
        end
        bring_up($urandom_range(0, 5), n);
        while (model_lost < 300) begin
            pll_lock = 1'b0;
            repeat (3) @(negedge clkin);
            model_lost++;
            if (model_lost == 254 || model_lost == 255 || model_lost == 256 || model_lost == 300) begin
                checks++;
                if (lock_lost_cnt !== sat8(model_lost)) begin
                    fails++;
                    $display("FAIL lost_count_sat: after %0d losses count=%0d, required %0d",
                             model_lost, lock_lost_cnt, sat8(model_lost));
                end
            end
            bring_up($urandom_range(0, 3), n);
            checks++;
            if (n !== RUN_LAT) begin
                fails++;
                $display("FAIL reacquire_latency: %0d cycles, required %0d", n, RUN_LAT);
                break;
            end
        end
    endtask

    task automatic test_async_reset();
        int g;
        logic [PW-1:0] p;
        p = PW'($urandom_range(1, NP - 1));
        request(p);
        pll_lock = 1'b0;
        g = 0;
        while (pll_reset !== 1'b0 && g < 50) begin
            @(negedge clkin);
            g++;
        end
        repeat (2) @(negedge clkin);
        pll_lock = 1'b1;
        repeat (5) @(negedge clkin);
        checks++;
        if (busy !== 1'b1 || pll_reset !== 1'b0 || cur_profile !== p) begin
            fails++;
            $display("FAIL stabilise_precondition: busy=%b prst=%b prof=%0d, required 1 0 %0d",
                     busy, pll_reset, cur_profile, p);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pll_reset, busy, sys_rst_n, clk_stable, error, req_ready} !== 6'b110000 ||
            cur_profile !== 2'd0 || lock_lost_cnt !== 8'd0 ||
            {pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(0)) begin
            fails++;
            $display("FAIL async_reset: flags=%b prof=%0d count=%0d sel=%h, required 110000 0 0 %h",
                     {pll_reset, busy, sys_rst_n, clk_stable, error, req_ready},
                     cur_profile, lock_lost_cnt, {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_up();
        test_reconfigure();
        test_nack();
        test_glitch();
        test_timeout_retry();
        test_lock_loss();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
